// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Shadow EX/MEM destination scoreboard producing registered
//            forwarding selects, load-use stall, branch flushes and
//            saturating stall/flush event counters.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             ID_insn_vld,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_rs1_use,
    input  logic             ID_rs2_use,
    input  logic [4:0]       ID_rd_addr,
    input  logic             ID_rd_wren,
    input  logic             ID_mem_rden,
    input  logic             EX_br_sel,
    output logic [1:0]       ID_forward_A,
    output logic [1:0]       ID_forward_B,
    output logic             o_stall,
    output logic             o_idex_bubble,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef struct packed {
        logic       vld;
        logic       wren;
        logic       load;
        logic [4:0] rd;
    } slot_t;

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_WB  = 2'b01;
    localparam logic [1:0] c_SEL_MEM = 2'b10;

    slot_t            r_ex;
    slot_t            r_mem;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_load_use;
    logic             w_stall;
    logic             w_flush;
    logic             w_issue;
    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;

    function automatic logic slot_match(slot_t s, logic [4:0] rs, logic use_rs, logic vld);
        return s.vld & s.wren & (s.rd != 5'd0) & (s.rd == rs) & use_rs & vld;
    endfunction

    // Youngest producer (EX) wins; a load in EX cannot forward and stalls instead.
    function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, logic [4:0] rs,
                                           logic use_rs, logic vld);
        if (slot_match(ex, rs, use_rs, vld) && !ex.load)
            return c_SEL_MEM;
        else if (slot_match(mem, rs, use_rs, vld))
            return c_SEL_WB;
        else
            return c_SEL_RF;
    endfunction

    always_comb begin
        w_load_use = r_ex.load &
                     (slot_match(r_ex, ID_rs1_addr, ID_rs1_use, ID_insn_vld) |
                      slot_match(r_ex, ID_rs2_addr, ID_rs2_use, ID_insn_vld));
        w_stall    = w_load_use & ~EX_br_sel & ~i_rst;
        w_flush    = EX_br_sel & ~i_rst;
        w_issue    = ~w_stall & ~EX_br_sel;
        w_sel_a    = fwd_sel(r_ex, r_mem, ID_rs1_addr, ID_rs1_use, ID_insn_vld);
        w_sel_b    = fwd_sel(r_ex, r_mem, ID_rs2_addr, ID_rs2_use, ID_insn_vld);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_fwd_a     <= c_SEL_RF;
            r_fwd_b     <= c_SEL_RF;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex    <= '{vld: ID_insn_vld, wren: ID_rd_wren,
                             load: ID_mem_rden, rd: ID_rd_addr};
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end else begin
                r_ex    <= '0;
                r_fwd_a <= c_SEL_RF;
                r_fwd_b <= c_SEL_RF;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (EX_br_sel && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign ID_forward_A  = r_fwd_a;
    assign ID_forward_B  = r_fwd_b;
    assign o_stall       = w_stall;
    assign o_idex_bubble = w_stall;
    assign o_ifid_flush  = w_flush;
    assign o_idex_flush  = w_flush;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

    localparam int c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_SAT = {c_CNT_W{1'b1}};

    logic               clk = 1'b0;
    logic               rst;
    logic               insn_vld;
    logic [4:0]         rs1, rs2, rd;
    logic               use1, use2, wren, load, br;
    logic [1:0]         fwd_a, fwd_b;
    logic               stall, bubble, ifid_flush, idex_flush;
    logic [c_CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_stall_cnt = 0;
    int exp_flush_cnt = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_W(c_CNT_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .ID_insn_vld   (insn_vld),
        .ID_rs1_addr   (rs1),
        .ID_rs2_addr   (rs2),
        .ID_rs1_use    (use1),
        .ID_rs2_use    (use2),
        .ID_rd_addr    (rd),
        .ID_rd_wren    (wren),
        .ID_mem_rden   (load),
        .EX_br_sel     (br),
        .ID_forward_A  (fwd_a),
        .ID_forward_B  (fwd_b),
        .o_stall       (stall),
        .o_idex_bubble (bubble),
        .o_ifid_flush  (ifid_flush),
        .o_idex_flush  (idex_flush),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    // Present an instruction in ID; settle before any combinational check.
    task automatic set_id(input logic v, input logic [4:0] a1, input logic u1,
                          input logic [4:0] a2, input logic u2, input logic [4:0] d,
                          input logic w, input logic ld);
        insn_vld = v; rs1 = a1; use1 = u1; rs2 = a2; use2 = u2;
        rd = d; wren = w; load = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        br = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; br = 1'b1;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd_a, fwd_b);
        end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        checks++;
        if ({stall, bubble, ifid_flush, idex_flush} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctl got=%b exp=0000",
                                 {stall, bubble, ifid_flush, idex_flush});
        end
        br = 1'b0; rst = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);  // addi x5,x0,1
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x5,x5
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL b2b_stall got=%b exp=0", stall);
        end
        step();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            failures++; $display("FAIL b2b_fwd got=%b/%b exp=10/10", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_distance();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);  // addi x5,x0,1
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // nop
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x5,x0
        step();
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL dist2_fwd got=%b/%b exp=01/00", fwd_a, fwd_b);
        end
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  // addi x9
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        step();
        set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 1'b0);  // add x1,x9,x9
        step();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL dist3_fwd got=%b/%b exp=00/00", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  // lw x7,0(x1)
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);  // add x8,x7,x1
        checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || ifid_flush !== 1'b0) begin
            failures++; $display("FAIL lu_stall got=%b%b%b exp=110", stall, bubble, ifid_flush);
        end
        step();
        exp_stall_cnt++;
        checks++;
        if (fwd_a !== 2'b00 || stall !== 1'b0) begin
            failures++; $display("FAIL lu_bubble got fwd=%b stall=%b exp fwd=00 stall=0",
                                 fwd_a, stall);
        end
        step();
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL lu_fwd got=%b/%b exp=01/00", fwd_a, fwd_b);
        end
        checks++;
        if (stall_cnt !== c_CNT_W'(exp_stall_cnt)) begin
            failures++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_stall_cnt);
        end
        drain();
    endtask

    task automatic test_x0_load();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);  // lw x0
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);  // add x8,x0,x0
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL x0_stall got=%b exp=0", stall);
        end
        step();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL x0_fwd got=%b/%b exp=00/00", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_youngest();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        step();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL young_fwd got=%b/%b exp=10/00", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_branch_stall();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        br = 1'b1;
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++;
        if ({stall, bubble, ifid_flush, idex_flush} !== 4'b0011) begin
            failures++; $display("FAIL br_ctl got=%b exp=0011",
                                 {stall, bubble, ifid_flush, idex_flush});
        end
        step();
        exp_flush_cnt++;
        br = 1'b0;
        #1;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            failures++; $display("FAIL br_after got fwd=%b/%b stall=%b exp 00/00 0",
                                 fwd_a, fwd_b, stall);
        end
        checks++;
        if (flush_cnt !== c_CNT_W'(exp_flush_cnt) || stall_cnt !== c_CNT_W'(exp_stall_cnt)) begin
            failures++; $display("FAIL br_cnt got=%0d/%0d exp=%0d/%0d",
                                 stall_cnt, flush_cnt, exp_stall_cnt, exp_flush_cnt);
        end
        drain();
    endtask

    task automatic test_saturation();
        // lw x7,0(x7) repeated: stalls every other cycle.
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (stall_cnt !== c_SAT) begin
            failures++; $display("FAIL sat_stall got=%0d exp=%0d", stall_cnt, c_SAT);
        end
        br = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (flush_cnt !== c_SAT || stall_cnt !== c_SAT) begin
            failures++; $display("FAIL sat_flush got=%0d/%0d exp=%0d/%0d",
                                 stall_cnt, flush_cnt, c_SAT, c_SAT);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        rst = 1'b1;
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            failures++; $display("FAIL rstmid_hold got=%b%b exp=00", stall, bubble);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL rstmid_after got stall=%b fwd=%b/%b exp 0 00/00",
                                 stall, fwd_a, fwd_b);
        end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        step();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            failures++; $display("FAIL rstmid_fwd got=%b/%b exp=00/00", fwd_a, fwd_b);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; br = 1'b0;
        insn_vld = 1'b0; rs1 = '0; rs2 = '0; use1 = 1'b0; use2 = 1'b0;
        rd = '0; wren = 1'b0; load = 1'b0;
        #2;
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_x0_load();
        test_youngest();
        test_branch_stall();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
